// File: rtl/gabor_window_gen_pkg.sv
// Shared definitions for the Gabor window generator: FSM state encoding
// and the padded-geometry derivation helpers used to size ports and counters.
package gabor_window_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic int row_w(input int img_w, input int k);
        return img_w + k - 1;
    endfunction

    function automatic int row_h(input int img_h, input int k);
        return img_h + k - 1;
    endfunction

    function automatic int addr_w(input int img_w, input int img_h, input int k);
        return $clog2(row_w(img_w, k) * row_h(img_h, k));
    endfunction

endpackage

// File: rtl/gabor_window_gen_line_buf.sv
// gabor_line_buf: single-row FIFO used as a fixed delay line of DEPTH pixels.
// Ports: clk, rst (async, clears pointer only), shift (push+pop), din, dout.
module gabor_line_buf #(
    parameter int DEPTH = 516,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;

    // The slot about to be overwritten holds the pixel pushed DEPTH shifts
    // ago, i.e. the same column one row earlier.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (shift) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (shift) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/gabor_window_gen.sv
// Gabor window generator: turns a padded raster pixel stream into KxK windows.
// Ports: clk, rst (async high); pix_in/pix_valid/pix_sof/pix_ready input stream;
// win_data/win_valid/win_ready/win_addr window stream; frame_done last-window pulse.
module gabor_window_gen
    import gabor_window_gen_pkg::*;
#(
    parameter int  PIX_W = 8,
    parameter int  IMG_W = 512,
    parameter int  IMG_H = 512,
    parameter int  K     = 5,
    localparam int ROW_W = row_w(IMG_W, K),
    localparam int ROW_H = row_h(IMG_H, K),
    localparam int AW    = addr_w(IMG_W, IMG_H, K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               pix_sof,
    output logic               pix_ready,
    output logic [K*K*PIX_W-1:0] win_data,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [AW-1:0]      win_addr,
    output logic               frame_done
);

    localparam int CW = $clog2(ROW_W);
    localparam int RW = $clog2(ROW_H);

    state_t         state;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic           win_last;

    logic           accept;
    logic           take;
    logic           emit;
    logic [CW-1:0]  cur_col;
    logic [RW-1:0]  cur_row;
    logic           col_last;
    logic           row_last;
    logic [AW-1:0]  addr_calc;

    logic [PIX_W-1:0] lb_out [K-1];
    logic [PIX_W-1:0] tap    [K];
    logic [PIX_W-1:0] sw     [K][K];

    assign pix_ready  = !win_valid || win_ready;
    assign accept     = pix_valid && pix_ready;
    // Non-sof pixels outside a frame are dropped: they neither advance
    // the counters nor shift the line buffers.
    assign take       = accept && (pix_sof || state == ST_FILL || state == ST_RUN);
    assign cur_col    = pix_sof ? '0 : col;
    assign cur_row    = pix_sof ? '0 : row;
    assign col_last   = cur_col == CW'(ROW_W - 1);
    assign row_last   = cur_row == RW'(ROW_H - 1);
    assign emit       = take && cur_row >= RW'(K - 1) && cur_col >= CW'(K - 1);
    assign addr_calc  = AW'(cur_row - RW'(K - 1)) * AW'(ROW_W)
                      + AW'(cur_col - CW'(K - 1));
    assign frame_done = win_valid && win_ready && win_last;

    // Line buffer i delays by (i+1) rows; chained so each feeds the next.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        if (i == 0) begin : g_first
            gabor_line_buf #(
                .DEPTH(ROW_W),
                .W    (PIX_W)
            ) u_lb (
                .clk  (clk),
                .rst  (rst),
                .shift(take),
                .din  (pix_in),
                .dout (lb_out[i])
            );
        end else begin : g_rest
            gabor_line_buf #(
                .DEPTH(ROW_W),
                .W    (PIX_W)
            ) u_lb (
                .clk  (clk),
                .rst  (rst),
                .shift(take),
                .din  (lb_out[i-1]),
                .dout (lb_out[i])
            );
        end
    end

    // tap[K-1] is the current row; tap[0] is the oldest (top) row.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            tap[r] = '0;
        end
        tap[K-1] = pix_in;
        for (int i = 0; i < K - 1; i++) begin
            tap[K-2-i] = lb_out[i];
        end
    end

    // Column shift window; it only moves on accepted pixels, so it also
    // holds steady while a window is stalled (pix_ready is low then).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    sw[r][c] <= '0;
                end
            end
        end else if (take) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    sw[r][c] <= sw[r][c+1];
                end
                sw[r][K-1] <= tap[r];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_data[(r*K+c)*PIX_W +: PIX_W] = sw[r][c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_addr  <= '0;
            win_last  <= 1'b0;
        end else begin
            if (win_valid && win_ready) begin
                win_valid <= 1'b0;
            end
            if (take) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? cur_row : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
                if (col_last && row_last) begin
                    state <= ST_DONE;
                end else if (cur_row == RW'(K - 1) && cur_col == CW'(K - 1)) begin
                    state <= ST_RUN;
                end else if (pix_sof) begin
                    state <= ST_FILL;
                end
                if (emit) begin
                    win_valid <= 1'b1;
                    win_addr  <= addr_calc;
                    win_last  <= col_last && row_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_gabor_window_gen.sv
// Directed bench for gabor_window_gen at K=3, 4x4 image (6x6 padded),
// pixel value equal to raster index; checks windows, stalls, restart, reset.
module tb_gabor_window_gen;

    localparam int PW = 8;
    localparam int KK = 3;
    localparam int RWD = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PW-1:0]     pix_in = '0;
    logic              pix_valid = 1'b0;
    logic              pix_sof = 1'b0;
    logic              pix_ready;
    logic [KK*KK*PW-1:0] win_data;
    logic              win_valid;
    logic              win_ready = 1'b1;
    logic [5:0]        win_addr;
    logic              frame_done;

    int nchk = 0;
    int nfail = 0;
    int nwin = 0;
    int nfd = 0;
    int last_addr = 0;
    int base_win;
    int base_fd;

    gabor_window_gen #(
        .PIX_W(PW),
        .IMG_W(4),
        .IMG_H(4),
        .K    (KK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_addr  (win_addr),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (win_valid && win_ready) begin
            nwin <= nwin + 1;
            last_addr <= int'(win_addr);
        end
        if (frame_done) begin
            nfd <= nfd + 1;
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int row, input int col);
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < KK; r++) begin
            for (int c = 0; c < KK; c++) begin
                v[(r*KK+c)*PW +: PW] = 8'((row - 2 + r) * RWD + (col - 2 + c));
            end
        end
        return v;
    endfunction

    task automatic send_px(input int idx, input bit sof, input bit live);
        int w;
        int row;
        int col;
        bit ew;
        @(negedge clk);
        pix_in = 8'(idx);
        pix_sof = sof;
        pix_valid = 1'b1;
        w = 0;
        while (!pix_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("pix_ready", {71'd0, pix_ready}, 72'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        row = idx / RWD;
        col = idx % RWD;
        ew = live && row >= 2 && col >= 2;
        chk("win_valid", {71'd0, win_valid}, {71'd0, ew});
        if (ew) begin
            chk("win_data", win_data, exp_win(row, col));
            chk("win_addr", {66'd0, win_addr},
                72'((row - 2) * RWD + col - 2));
        end
        chk("frame_done", {71'd0, frame_done}, {71'd0, live && idx == 35});
    endtask

    task automatic frame_totals(input string tag, input int exp_n);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_count"}, 72'(nwin - base_win), 72'(exp_n));
        if (exp_n > 0) begin
            chk({tag, "_last_addr"}, 72'(last_addr), 72'd21);
            chk({tag, "_done_pulses"}, 72'(nfd - base_fd), 72'd1);
        end
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_win_valid", {71'd0, win_valid}, 72'd0);
        chk("rst_win_data", win_data, 72'd0);
        chk("rst_win_addr", {66'd0, win_addr}, 72'd0);
        chk("rst_frame_done", {71'd0, frame_done}, 72'd0);
        chk("rst_pix_ready", {71'd0, pix_ready}, 72'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // non-sof pixel in IDLE is dropped
        send_px(14, 1'b0, 1'b0);

        // full ramp frame
        base_win = nwin;
        base_fd = nfd;
        for (int i = 0; i < 36; i++) begin
            send_px(i, i == 0, 1'b1);
        end
        frame_totals("ramp", 16);

        // backpressure on the first window
        base_win = nwin;
        base_fd = nfd;
        for (int i = 0; i < 15; i++) begin
            send_px(i, i == 0, 1'b1);
        end
        @(negedge clk);
        win_ready = 1'b0;
        pix_valid = 1'b1;
        pix_in = 8'd15;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk);
            #1;
            chk("stall_pix_ready", {71'd0, pix_ready}, 72'd0);
            chk("stall_win_valid", {71'd0, win_valid}, 72'd1);
            chk("stall_win_data", win_data, exp_win(2, 2));
            chk("stall_win_addr", {66'd0, win_addr}, 72'd0);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        win_ready = 1'b1;
        for (int i = 15; i < 36; i++) begin
            send_px(i, 1'b0, 1'b1);
        end
        frame_totals("stall", 16);

        // sof reasserted mid-frame at pixel 20
        for (int i = 0; i < 20; i++) begin
            send_px(i, i == 0, 1'b1);
        end
        base_win = nwin;
        base_fd = nfd;
        for (int i = 0; i < 36; i++) begin
            send_px(i, i == 0, 1'b1);
        end
        frame_totals("restart", 16);

        // reset mid-frame at pixel 17
        for (int i = 0; i < 18; i++) begin
            send_px(i, i == 0, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_win_valid", {71'd0, win_valid}, 72'd0);
        chk("midrst_win_addr", {66'd0, win_addr}, 72'd0);
        chk("midrst_pix_ready", {71'd0, pix_ready}, 72'd1);
        @(negedge clk);
        rst = 1'b0;
        base_win = nwin;
        base_fd = nfd;
        for (int i = 18; i < 36; i++) begin
            send_px(i, 1'b0, 1'b0);
        end
        frame_totals("dropped", 0);
        chk("dropped_done_pulses", 72'(nfd - base_fd), 72'd0);

        base_win = nwin;
        base_fd = nfd;
        for (int i = 0; i < 36; i++) begin
            send_px(i, i == 0, 1'b1);
        end
        frame_totals("after_rst", 16);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
